// File: rtl/slot_sched_timer.sv
// TDMA slot scheduler: tick prescaler, slot boundary, DSP slot IRQ,
// programmable in-slot event channels and one-slot length adjustment.
`timescale 1ns/1ps

module slot_sched_timer #(
    parameter int TICK_DIV = 2000,
    parameter int LEN_W    = 15,
    parameter int SLOT_LEN = 1625,
    parameter int NUM_EVT  = 4,
    parameter int IRQ_W    = 100
) (
    input  logic                     clk_50mhz,
    input  logic                     cfg_rst,
    input  logic                     start,
    input  logic                     adj_en,
    input  logic [LEN_W-1:0]         adj_len,
    input  logic [NUM_EVT*LEN_W-1:0] evt_off,
    input  logic [NUM_EVT-1:0]       evt_mode,
    output logic                     slot_pulse,
    output logic                     slot_irq,
    output logic [NUM_EVT-1:0]       evt_pulse,
    output logic [NUM_EVT-1:0]       evt_level,
    output logic                     adjusting,
    output logic [LEN_W-1:0]         tick_cnt,
    output logic [15:0]              slot_idx
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = $clog2(IRQ_W + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_MID  = PW'(TICK_DIV / 2 - 1);
    localparam logic [LEN_W-1:0] NOM_LEN    = LEN_W'(SLOT_LEN);
    localparam logic [IW-1:0]    IRQ_LOAD   = IW'(IRQ_W - 1);

    logic [PW-1:0]      presc;
    logic [LEN_W-1:0]   cur_len;
    logic [LEN_W-1:0]   adj_len_q;
    logic               pend;
    logic [IW-1:0]      irq_cnt;

    logic               tick_end;
    logic               slot_end;
    logic               mid_tick;
    logic [LEN_W-1:0]   next_len;
    logic [NUM_EVT-1:0] hit;

    always_comb begin
        tick_end = start && (presc == PRESC_LAST);
        slot_end = tick_end && (tick_cnt == cur_len - LEN_W'(1));
        mid_tick = start && (presc == PRESC_MID);
        if (!pend)
            next_len = NOM_LEN;
        else if (adj_len_q == '0)
            next_len = LEN_W'(1);
        else
            next_len = adj_len_q;
    end

    // An offset beyond the current slot length can never match.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            hit[i] = mid_tick
                  && (tick_cnt == evt_off[i*LEN_W +: LEN_W])
                  && (evt_off[i*LEN_W +: LEN_W] < cur_len);
        end
    end

    always_ff @(posedge clk_50mhz or posedge cfg_rst) begin
        if (cfg_rst) begin
            presc      <= '0;
            tick_cnt   <= '0;
            slot_idx   <= '0;
            cur_len    <= NOM_LEN;
            adj_len_q  <= '0;
            pend       <= 1'b0;
            adjusting  <= 1'b0;
            slot_pulse <= 1'b0;
            slot_irq   <= 1'b0;
            irq_cnt    <= '0;
            evt_pulse  <= '0;
            evt_level  <= '0;
        end else begin
            slot_pulse <= slot_end;

            if (start)
                presc <= tick_end ? '0 : presc + PW'(1);

            if (tick_end)
                tick_cnt <= slot_end ? '0 : tick_cnt + LEN_W'(1);

            if (slot_end) begin
                slot_idx <= slot_idx + 16'd1;
                cur_len  <= next_len;
            end

            // A request on the boundary edge targets the following boundary.
            if (adj_en) begin
                adj_len_q <= adj_len;
                pend      <= 1'b1;
            end else if (slot_end) begin
                pend <= 1'b0;
            end

            adjusting <= adj_en || (adjusting && !(slot_end && !pend));

            if (slot_end && !adjusting) begin
                slot_irq <= 1'b1;
                irq_cnt  <= IRQ_LOAD;
            end else if (adjusting) begin
                slot_irq <= 1'b0;
                irq_cnt  <= '0;
            end else if (slot_irq) begin
                if (irq_cnt == '0)
                    slot_irq <= 1'b0;
                else
                    irq_cnt <= irq_cnt - IW'(1);
            end

            for (int i = 0; i < NUM_EVT; i++) begin
                evt_pulse[i] <= hit[i] && !(evt_mode[i] && evt_level[i]);
                if (hit[i] && evt_mode[i])
                    evt_level[i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slot_sched_timer.sv
// Bench for slot_sched_timer: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a slot-position reference model.
`timescale 1ns/1ps

module tb_slot_sched_timer;

    localparam int TD = 4;
    localparam int LW = 8;
    localparam int SL = 5;
    localparam int NE = 4;
    localparam int IW = 3;

    logic            clk_50mhz = 1'b0;
    logic            cfg_rst   = 1'b1;
    logic            start     = 1'b0;
    logic            adj_en    = 1'b0;
    logic [LW-1:0]   adj_len   = '0;
    logic [NE*LW-1:0] evt_off  = '0;
    logic [NE-1:0]   evt_mode  = '0;

    logic            slot_pulse;
    logic            slot_irq;
    logic [NE-1:0]   evt_pulse;
    logic [NE-1:0]   evt_level;
    logic            adjusting;
    logic [LW-1:0]   tick_cnt;
    logic [15:0]     slot_idx;

    slot_sched_timer #(
        .TICK_DIV (TD),
        .LEN_W    (LW),
        .SLOT_LEN (SL),
        .NUM_EVT  (NE),
        .IRQ_W    (IW)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .cfg_rst    (cfg_rst),
        .start      (start),
        .adj_en     (adj_en),
        .adj_len    (adj_len),
        .evt_off    (evt_off),
        .evt_mode   (evt_mode),
        .slot_pulse (slot_pulse),
        .slot_irq   (slot_irq),
        .evt_pulse  (evt_pulse),
        .evt_level  (evt_level),
        .adjusting  (adjusting),
        .tick_cnt   (tick_cnt),
        .slot_idx   (slot_idx)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: position in clock cycles within the current slot
    int      m_pos, m_len, m_slot, m_alen, m_irq;
    bit      m_pend, m_adj, m_sp;
    bit [NE-1:0] m_ep, m_el;

    function automatic int off_of(int i);
        return int'(evt_off[i*LW +: LW]);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_len = SL; m_slot = 0; m_alen = 0; m_irq = 0;
        m_pend = 0; m_adj = 0; m_sp = 0; m_ep = '0; m_el = '0;
    endtask

    task automatic model_step();
        bit se;
        bit f;
        int o;
        se = start && (m_pos == m_len * TD - 1);
        for (int i = 0; i < NE; i++) begin
            o = off_of(i);
            f = start && (m_pos % TD == TD / 2 - 1)
                && (m_pos / TD == o) && (o < m_len);
            m_ep[i] = f && !(evt_mode[i] && m_el[i]);
            if (f && evt_mode[i]) m_el[i] = 1'b1;
        end
        if (se && !m_adj) m_irq = IW;
        else if (m_adj) m_irq = 0;
        else if (m_irq > 0) m_irq = m_irq - 1;
        m_sp  = se;
        m_adj = adj_en || (m_adj && !(se && !m_pend));
        if (se) begin
            m_slot = (m_slot + 1) % 65536;
            m_len  = m_pend ? ((m_alen == 0) ? 1 : m_alen) : SL;
        end
        if (adj_en) begin
            m_pend = 1'b1;
            m_alen = int'(adj_len);
        end else if (se) begin
            m_pend = 1'b0;
        end
        if (start) m_pos = se ? 0 : m_pos + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("slot_pulse", 32'(slot_pulse), 32'(m_sp));
        chk("slot_irq",   32'(slot_irq),   32'(m_irq > 0));
        chk("adjusting",  32'(adjusting),  32'(m_adj));
        chk("tick_cnt",   32'(tick_cnt),   32'(m_pos / TD));
        chk("slot_idx",   32'(slot_idx),   32'(m_slot));
        chk("evt_pulse",  32'(evt_pulse),  32'(m_ep));
        chk("evt_level",  32'(evt_level),  32'(m_el));
    endtask

    task automatic cyc();
        @(posedge clk_50mhz);
        if (cfg_rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    // Cycles up to and including the next observed slot_pulse (bounded)
    task automatic wait_sp(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (slot_pulse !== 1'b1 && n < 400);
    endtask

    int n;

    initial begin
        model_reset();
        evt_off  = {8'd4, 8'd2, 8'd0, 8'd7};
        evt_mode = 4'b0100;

        cyc();
        cyc();
        cfg_rst = 1'b0;
        cyc();
        cyc();

        // Free run with events
        start = 1'b1;
        wait_sp(n);
        chk("first_gap", n, 20);
        wait_sp(n);
        chk("gap2", n, 20);
        wait_sp(n);
        chk("gap3", n, 20);
        chk("idx3", 32'(slot_idx), 3);
        chk("ch2_level", 32'(evt_level), 32'h4);

        // One-slot adjustment to 2 ticks
        repeat (5) cyc();
        adj_en = 1'b1; adj_len = 8'd2;
        cyc();
        adj_en = 1'b0;
        chk("adj_rise", 32'(adjusting), 1);
        wait_sp(n);
        chk("adj_open_irq", 32'(slot_irq), 0);
        wait_sp(n);
        chk("adj_slot", n, 8);
        chk("adj_close_irq", 32'(slot_irq), 0);
        wait_sp(n);
        chk("post_adj", n, 20);
        chk("irq_back", 32'(slot_irq), 1);

        // Zero length clamps to one tick
        repeat (3) cyc();
        adj_en = 1'b1; adj_len = 8'd0;
        cyc();
        adj_en = 1'b0;
        wait_sp(n);
        wait_sp(n);
        chk("len0", n, 4);
        wait_sp(n);
        chk("len0_after", n, 20);

        // Request on the boundary edge itself
        repeat (19) cyc();
        adj_en = 1'b1; adj_len = 8'd1;
        cyc();
        adj_en = 1'b0;
        chk("coinc_sp", 32'(slot_pulse), 1);
        wait_sp(n);
        chk("coinc_next", n, 20);
        wait_sp(n);
        chk("coinc_adj", n, 4);
        wait_sp(n);

        // Two requests in one slot
        repeat (3) cyc();
        adj_en = 1'b1; adj_len = 8'd3;
        cyc();
        adj_en = 1'b0;
        repeat (2) cyc();
        adj_en = 1'b1; adj_len = 8'd1;
        cyc();
        adj_en = 1'b0;
        wait_sp(n);
        wait_sp(n);
        chk("last_wins", n, 4);
        wait_sp(n);

        // Start gating for 7 cycles
        repeat (5) cyc();
        start = 1'b0;
        repeat (7) cyc();
        start = 1'b1;
        wait_sp(n);
        chk("gated", n + 12, 27);

        // Reset mid-slot
        repeat (6) cyc();
        chk("lvl_pre_rst", 32'(evt_level[2]), 1);
        cfg_rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_level", 32'(evt_level), 0);
        repeat (2) cyc();
        cfg_rst = 1'b0;
        wait_sp(n);
        chk("restart", n, 20);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            start = 1'b0;
            cyc();
            for (int i = 0; i < NE; i++)
                evt_off[i*LW +: LW] = LW'($urandom_range(0, 7));
            evt_mode = NE'($urandom);
            cfg_rst = 1'b1;
            cyc();
            cfg_rst = 1'b0;
            for (int k = 0; k < 300; k++) begin
                start   = ($urandom_range(0, 9) != 0);
                adj_en  = ($urandom_range(0, 39) == 0);
                adj_len = LW'($urandom_range(0, 6));
                cyc();
            end
            adj_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
